// File: rtl/nco_ctrl_pkg.sv
// nco_ctrl_pkg: shared types and widths for the NCO tuning controller
package nco_ctrl_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_HOLD, ST_REPEAT, ST_CHORD} state_e;
  typedef enum logic {DIR_UP, DIR_DN} dir_e;
  localparam int SHIFT_W = 5;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer plus stability filter for an active-low button, with press/release pulses
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 270000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_n_i,
  output logic pressed_o,
  output logic press_o,
  output logic release_o
);
  localparam int CW = $clog2(DEBOUNCE_CYC) + 1;
  logic [1:0] sync_q;
  logic lvl_q, lvl_d, press_q, rel_q, diff, adopt;
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    diff = sync_q[1] != lvl_q;
    adopt = diff && cnt_q == CW'(DEBOUNCE_CYC - 1);
    cnt_d = (diff && !adopt) ? cnt_q + CW'(1) : '0;
    lvl_d = adopt ? sync_q[1] : lvl_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '1;
      lvl_q <= 1'b1;
      cnt_q <= '0;
      press_q <= 1'b0;
      rel_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_n_i};
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
      press_q <= adopt & ~sync_q[1];
      rel_q <= adopt & sync_q[1];
    end
  end
  assign pressed_o = ~lvl_q;
  assign press_o = press_q;
  assign release_o = rel_q;
endmodule

// File: rtl/nco_tuning_ctrl.sv
// nco_tuning_ctrl: button-driven saturating tuning word with auto-repeat, acceleration and toggle req/ack publish
module nco_tuning_ctrl
  import nco_ctrl_pkg::*;
#(
  parameter int               WIDTH        = 32,
  parameter logic [WIDTH-1:0] INC_RESET    = WIDTH'(1),
  parameter int               DEBOUNCE_CYC = 270000,
  parameter int               REPEAT_DELAY = 13500000,
  parameter int               REPEAT_RATE  = 2700000,
  parameter int               ACCEL_COUNT  = 8,
  parameter int               STEP_MAX     = 24
) (
  input  logic               in_clk,
  input  logic               rst_n,
  input  logic               btn1,
  input  logic               btn2,
  input  logic               upd_ack,
  output logic [WIDTH-1:0]   inc_out,
  output logic               upd_req,
  output logic [SHIFT_W-1:0] step_shift,
  output logic               busy
);
  localparam int TW = $clog2(REPEAT_DELAY > REPEAT_RATE ? REPEAT_DELAY : REPEAT_RATE) + 1;
  localparam int AW = $clog2(ACCEL_COUNT) + 1;
  state_e state_q, state_d;
  dir_e dir_q, dir_d, step_dir;
  logic p1, p2, r1, r2, d1, d2;
  logic hr, oth_p, own_r, expired, act_zero, act_rep, act_step;
  logic [WIDTH-1:0] inc_q, inc_d, out_q, out_d;
  logic [WIDTH:0] step, sum, dif;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [SHIFT_W-1:0] shift_q, shift_d;
  logic [1:0] ack_q;
  logic chg_q, chg_d, pend_q, pend_d, req_q, req_d, busy_w, want, pub, acc_wrap;
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn1 (
    .clk(in_clk), .rst_n(rst_n), .btn_n_i(btn1), .pressed_o(d1), .press_o(p1), .release_o(r1)
  );
  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_btn2 (
    .clk(in_clk), .rst_n(rst_n), .btn_n_i(btn2), .pressed_o(d2), .press_o(p2), .release_o(r2)
  );
  always_comb begin
    hr = state_q == ST_HOLD || state_q == ST_REPEAT;
    oth_p = dir_q == DIR_UP ? p2 : p1;
    own_r = dir_q == DIR_UP ? r1 : r2;
    expired = tmr_q == (state_q == ST_HOLD ? TW'(REPEAT_DELAY - 1) : TW'(REPEAT_RATE - 1));
  end
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    case (state_q)
      ST_IDLE: begin
        state_d = (p1 && p2) ? ST_CHORD : (p1 || p2) ? ST_HOLD : ST_IDLE;
        dir_d = (p1 ^ p2) ? (p1 ? DIR_UP : DIR_DN) : dir_q;
      end
      ST_HOLD, ST_REPEAT: state_d = oth_p ? ST_CHORD : own_r ? ST_IDLE : expired ? ST_REPEAT : state_q;
      default: state_d = (d1 || d2) ? ST_CHORD : ST_IDLE;
    endcase
  end
  always_comb begin
    act_zero = (state_q == ST_IDLE && p1 && p2) || (hr && oth_p);
    act_rep = hr && !oth_p && !own_r && expired;
    act_step = (state_q == ST_IDLE && (p1 ^ p2)) || act_rep;
    step_dir = state_q == ST_IDLE ? (p1 ? DIR_UP : DIR_DN) : dir_q;
  end
  // Extra MSB catches carry/borrow so both directions clamp instead of wrapping.
  always_comb begin
    step = (WIDTH+1)'(1) << shift_q;
    sum = {1'b0, inc_q} + step;
    dif = {1'b0, inc_q} - step;
    inc_d = act_zero ? '0 : !act_step ? inc_q : step_dir == DIR_UP ? (sum[WIDTH] ? '1 : sum[WIDTH-1:0])
          : (dif[WIDTH] ? '0 : dif[WIDTH-1:0]);
    chg_d = inc_d != inc_q;
    tmr_d = (hr && state_d == state_q && !act_rep) ? tmr_q + TW'(1) : '0;
    acc_wrap = acc_q == AW'(ACCEL_COUNT - 1);
    acc_d = state_d == ST_IDLE ? '0 : act_rep ? (acc_wrap ? '0 : acc_q + AW'(1)) : acc_q;
    shift_d = state_d == ST_IDLE ? '0
            : (act_rep && acc_wrap && shift_q < SHIFT_W'(STEP_MAX)) ? shift_q + SHIFT_W'(1) : shift_q;
  end
  // A change seen while busy is parked; only the newest word goes out once ack catches up.
  always_comb begin
    busy_w = req_q != ack_q[1];
    want = chg_q | pend_q;
    pub = want & ~busy_w;
    out_d = pub ? inc_q : out_q;
    req_d = req_q ^ pub;
    pend_d = want & busy_w;
  end
  always_ff @(posedge in_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      dir_q <= DIR_UP;
      inc_q <= INC_RESET;
      out_q <= INC_RESET;
      chg_q <= 1'b0;
      pend_q <= 1'b0;
      req_q <= 1'b0;
      ack_q <= '0;
      tmr_q <= '0;
      acc_q <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      inc_q <= inc_d;
      out_q <= out_d;
      chg_q <= chg_d;
      pend_q <= pend_d;
      req_q <= req_d;
      ack_q <= {ack_q[0], upd_ack};
      tmr_q <= tmr_d;
      acc_q <= acc_d;
      shift_q <= shift_d;
    end
  end
  assign inc_out = out_q;
  assign upd_req = req_q;
  assign step_shift = shift_q;
  assign busy = busy_w;
endmodule

// File: tb/tb_nco_tuning_ctrl.sv
// tb_nco_tuning_ctrl: randomized and directed checks of the tuning controller against an event-level model
module tb_nco_tuning_ctrl;
  localparam int W = 32;
  localparam int DEB = 4;
  localparam int REPD = 20;
  localparam int RATE = 5;
  localparam int ACC = 4;
  localparam int SMAX = 24;
  localparam logic [63:0] MAXV = 64'hFFFF_FFFF;
  localparam logic [W-1:0] ALL1 = 32'hFFFF_FFFF;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic btn1 = 1'b1;
  logic btn2 = 1'b1;
  logic ack_hold = 1'b0;
  logic upd_ack, upd_req, busy, req_prev;
  logic [W-1:0] inc_out;
  logic [4:0] step_shift;
  logic [2:0] ack_pipe;
  logic [W-1:0] rx_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] model_inc;
  int checks = 0;
  int failures = 0;
  int tgl_cnt = 0;

  nco_tuning_ctrl #(
    .WIDTH(W), .INC_RESET(32'd1), .DEBOUNCE_CYC(DEB), .REPEAT_DELAY(REPD),
    .REPEAT_RATE(RATE), .ACCEL_COUNT(ACC), .STEP_MAX(SMAX)
  ) dut (
    .in_clk(clk), .rst_n(rst_n), .btn1(btn1), .btn2(btn2), .upd_ack(upd_ack),
    .inc_out(inc_out), .upd_req(upd_req), .step_shift(step_shift), .busy(busy)
  );

  always #5 clk = ~clk;

  // NCO-side receiver: logs every published word, returns the ack 3 cycles later
  assign upd_ack = ack_pipe[2];
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_pipe <= '0;
      req_prev <= 1'b0;
    end else begin
      if (!ack_hold) ack_pipe <= {ack_pipe[1:0], upd_req};
      req_prev <= upd_req;
      if (upd_req != req_prev) begin
        tgl_cnt <= tgl_cnt + 1;
        rx_q.push_back(inc_out);
      end
    end
  end

  task automatic press(input int b, input int h);
    @(posedge clk);
    #1;
    if (b == 1) btn1 = 1'b0; else btn2 = 1'b0;
    repeat (h) @(posedge clk);
    #1;
    if (b == 1) btn1 = 1'b1; else btn2 = 1'b1;
  endtask

  // Steps of a clean hold of h cycles: press at 0, first repeat at REPD, then every RATE, before release
  task automatic model_hold(input bit up, input int h);
    logic [63:0] v, st;
    int sh;
    for (int j = 0; j == 0 || REPD + RATE * (j - 1) < h; j++) begin
      sh = (j == 0) ? 0 : ((j - 1) / ACC > SMAX ? SMAX : (j - 1) / ACC);
      st = 64'd1 << sh;
      v = {32'd0, model_inc};
      v = up ? ((v + st > MAXV) ? MAXV : v + st) : ((v < st) ? 64'd0 : v - st);
      if (v[W-1:0] != model_inc) exp_q.push_back(v[W-1:0]);
      model_inc = v[W-1:0];
    end
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (inc_out !== 32'd1) begin failures++; $display("FAIL reset_inc got=%0h exp=1", inc_out); end
    checks++; if (upd_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", upd_req); end
    checks++; if (step_shift !== 5'd0) begin failures++; $display("FAIL reset_shift got=%0d exp=0", step_shift); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rst_n = 1'b1;
    model_inc = 32'd1;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (inc_out !== 32'd1) begin failures++; $display("FAIL idle_inc got=%0h exp=1", inc_out); end
  endtask

  task automatic test_bounce;
    int t0;
    t0 = tgl_cnt;
    press(1, 2);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (inc_out !== model_inc) begin failures++; $display("FAIL glitch_inc got=%0h exp=%0h", inc_out, model_inc); end
    checks++; if (tgl_cnt != t0) begin failures++; $display("FAIL glitch_tgl got=%0d exp=%0d", tgl_cnt, t0); end
    model_hold(1'b1, 10);
    press(1, 10);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (inc_out !== 32'd2) begin failures++; $display("FAIL bounce_inc got=%0h exp=2", inc_out); end
    checks++; if (tgl_cnt != t0 + 1) begin failures++; $display("FAIL bounce_tgl got=%0d exp=%0d", tgl_cnt, t0 + 1); end
  endtask

  task automatic test_reset_mid;
    @(posedge clk);
    #1 btn1 = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    checks++; if (step_shift !== 5'd1) begin failures++; $display("FAIL mid_shift_pre got=%0d exp=1", step_shift); end
    rst_n = 1'b0;
    #1;
    checks++; if (inc_out !== 32'd1) begin failures++; $display("FAIL mid_reset_inc got=%0h exp=1", inc_out); end
    checks++; if (upd_req !== 1'b0) begin failures++; $display("FAIL mid_reset_req got=%b exp=0", upd_req); end
    checks++; if (step_shift !== 5'd0) begin failures++; $display("FAIL mid_reset_shift got=%0d exp=0", step_shift); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_reset_busy got=%b exp=0", busy); end
    btn1 = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    model_inc = 32'd1;
    repeat (10) @(posedge clk);
  endtask

  task automatic test_hold;
    model_hold(1'b1, 38);
    press(1, 38);
    repeat (5) @(posedge clk);
    #1;
    checks++; if (step_shift !== 5'd1) begin failures++; $display("FAIL hold_accel got=%0d exp=1", step_shift); end
    repeat (20) @(posedge clk);
    #1;
    checks++; if (inc_out !== 32'd6 || model_inc !== 32'd6) begin failures++; $display("FAIL hold_inc got=%0h exp=6", inc_out); end
    checks++; if (step_shift !== 5'd0) begin failures++; $display("FAIL hold_release_shift got=%0d exp=0", step_shift); end
  endtask

  task automatic test_random;
    int r0, t0, h, k;
    bit up, ok;
    for (int n = 0; n < 8; n++) begin
      up = 1'($urandom_range(0, 1));
      h = $urandom_range(5, 70);
      exp_q.delete();
      r0 = rx_q.size();
      t0 = tgl_cnt;
      model_hold(up, h);
      press(up ? 1 : 2, h);
      repeat (30) @(posedge clk);
      #1;
      checks++; if (inc_out !== model_inc) begin failures++; $display("FAIL rand_inc h=%0d got=%0h exp=%0h", h, inc_out, model_inc); end
      checks++; if (step_shift !== 5'd0) begin failures++; $display("FAIL rand_shift got=%0d exp=0", step_shift); end
      checks++; if ((tgl_cnt == t0) != (exp_q.size() == 0)) begin failures++; $display("FAIL rand_tgl got=%0d exp_changes=%0d", tgl_cnt - t0, exp_q.size()); end
      ok = 1'b1;
      k = 0;
      for (int i = r0; i < rx_q.size(); i++) begin
        while (k < exp_q.size() && exp_q[k] != rx_q[i]) k++;
        if (k == exp_q.size()) ok = 1'b0; else k++;
      end
      checks++; if (!ok) begin failures++; $display("FAIL rand_order published=%0d expected_seq=%0d", rx_q.size() - r0, exp_q.size()); end
    end
  endtask

  task automatic test_chord;
    int t1;
    @(posedge clk);
    #1 btn1 = 1'b0;
    repeat (30) @(posedge clk);
    #1 btn2 = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    checks++; if (inc_out !== 32'd0) begin failures++; $display("FAIL chord_inc got=%0h exp=0", inc_out); end
    t1 = tgl_cnt;
    repeat (5) @(posedge clk);
    #1;
    btn1 = 1'b1;
    btn2 = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    model_inc = 32'd0;
    checks++; if (inc_out !== 32'd0) begin failures++; $display("FAIL chord_hold_inc got=%0h exp=0", inc_out); end
    checks++; if (tgl_cnt != t1) begin failures++; $display("FAIL chord_quiet got=%0d exp=%0d", tgl_cnt, t1); end
    checks++; if (rx_q[rx_q.size() - 1] !== 32'd0) begin failures++; $display("FAIL chord_rx got=%0h exp=0", rx_q[rx_q.size() - 1]); end
    checks++; if (step_shift !== 5'd0) begin failures++; $display("FAIL chord_shift got=%0d exp=0", step_shift); end
  endtask

  task automatic test_saturation;
    int t0;
    t0 = tgl_cnt;
    model_hold(1'b0, 8);
    press(2, 8);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (inc_out !== 32'd0) begin failures++; $display("FAIL sat_dn_inc got=%0h exp=0", inc_out); end
    checks++; if (tgl_cnt != t0) begin failures++; $display("FAIL sat_dn_tgl got=%0d exp=%0d", tgl_cnt, t0); end
    model_hold(1'b1, 2000);
    press(1, 2000);
    repeat (40) @(posedge clk);
    #1;
    checks++; if (inc_out !== ALL1 || inc_out !== model_inc) begin failures++; $display("FAIL sat_up_inc got=%0h exp=%0h", inc_out, ALL1); end
    t0 = tgl_cnt;
    model_hold(1'b1, 8);
    press(1, 8);
    repeat (20) @(posedge clk);
    #1;
    checks++; if (inc_out !== ALL1) begin failures++; $display("FAIL sat_up_hold got=%0h exp=%0h", inc_out, ALL1); end
    checks++; if (tgl_cnt != t0) begin failures++; $display("FAIL sat_up_tgl got=%0d exp=%0d", tgl_cnt, t0); end
  endtask

  task automatic test_back_to_back;
    int t0;
    logic [W-1:0] first;
    @(posedge clk);
    #1 ack_hold = 1'b1;
    t0 = tgl_cnt;
    exp_q.delete();
    for (int n = 0; n < 3; n++) begin
      model_hold(1'b0, 8);
      press(2, 8);
      repeat (12) @(posedge clk);
      #1;
      first = exp_q[0];
      checks++; if (inc_out !== first) begin failures++; $display("FAIL bp_frozen n=%0d got=%0h exp=%0h", n, inc_out, first); end
    end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_busy got=%b exp=1", busy); end
    checks++; if (tgl_cnt != t0 + 1) begin failures++; $display("FAIL bp_tgl_held got=%0d exp=%0d", tgl_cnt - t0, 1); end
    ack_hold = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    checks++; if (inc_out !== model_inc || model_inc !== ALL1 - 32'd3) begin failures++; $display("FAIL bp_latest got=%0h exp=%0h", inc_out, ALL1 - 32'd3); end
    checks++; if (tgl_cnt != t0 + 2) begin failures++; $display("FAIL bp_tgl_total got=%0d exp=%0d", tgl_cnt - t0, 2); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL bp_busy_clear got=%b exp=0", busy); end
  endtask

  initial begin
    test_reset;
    test_bounce;
    test_reset_mid;
    test_hold;
    test_random;
    test_chord;
    test_saturation;
    test_back_to_back;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
